csd2bin_serial: RTL



---
 rtl/csd2bin_serial.sv | 98 +++++++++
 1 files changed

// File: rtl/csd2bin_serial.sv
// Digit-serial CSD-to-two's-complement converter with valid/ready handshakes.
// Resolves one signed digit per clock, LSB first, using a single-bit borrow.
module csd2bin_serial #(
  parameter int W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     y,
  output logic             err_digit,
  output logic             ovf
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t         state, state_nx;
  logic [2*W-1:0] sr;
  logic [CW-1:0]  cnt;
  logic           borrow;
  logic           err_acc;

  logic           dig_bad;
  logic           dig_p;
  logic           dig_n;
  logic           res_bit;
  logic           borrow_nx;
  logic           accept;
  logic           last_dig;

  // An illegal 11 digit is folded to zero before entering the borrow chain.
  always_comb begin
    dig_bad   = sr[1] & sr[0];
    dig_p     = sr[1] & ~dig_bad;
    dig_n     = sr[0] & ~dig_bad;
    res_bit   = dig_p ^ dig_n ^ borrow;
    borrow_nx = ~dig_p & (dig_n | borrow);
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && (state == IDLE);
  assign last_dig  = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid) state_nx = CONV;
      CONV:    if (last_dig) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      cnt       <= '0;
      borrow    <= 1'b0;
      err_acc   <= 1'b0;
      y         <= '0;
      err_digit <= 1'b0;
      ovf       <= 1'b0;
    end else if (accept) begin
      sr        <= x;
      cnt       <= '0;
      borrow    <= 1'b0;
      err_acc   <= 1'b0;
      y         <= '0;
      err_digit <= 1'b0;
      ovf       <= 1'b0;
    end else if (state == CONV) begin
      sr      <= {2'b00, sr[2*W-1:2]};
      y       <= {res_bit, y[W-1:1]};
      borrow  <= borrow_nx;
      err_acc <= err_acc | dig_bad;
      if (last_dig) begin
        // Final borrow is the true sign; disagreement with the MSB means overflow.
        ovf       <= borrow_nx ^ res_bit;
        err_digit <= err_acc | dig_bad;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
